// File: rtl/run_ctrl.sv
// Run/stop controller: debounced RUN/STOP/STEP buttons, instruction-boundary
// start/stop, HLT handling and a completed-instruction counter.
module run_ctrl #(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_stop,
  input  logic        btn_step,
  input  logic        t7,
  input  logic        hlt_req,
  output logic        halt,
  output logic        running,
  output logic        step_done,
  output logic [15:0] cyc_cnt
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_e;

  logic [1:0] rs_q;
  logic       rst_n;

  // Asynchronous assert, synchronous release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rs_q <= 2'b00;
    else      rs_q <= {rs_q[0], 1'b1};
  end

  assign rst_n = rs_q[1];

  logic [2:0] btn;
  logic [2:0] s1_q;
  logic [2:0] s2_q;
  logic [2:0] deb_q;
  logic [2:0] debd_q;
  logic [7:0] cnt_q [3];

  assign btn = {btn_step, btn_stop, btn_run};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      debd_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= btn;
      s2_q   <= s1_q;
      debd_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          deb_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  logic [2:0] ev;
  logic       ev_stop;
  logic       ev_step;
  logic       ev_run;

  // STOP > STEP > RUN
  assign ev      = deb_q & ~debd_q;
  assign ev_stop = ev[1];
  assign ev_step = ev[2] & ~ev[1];
  assign ev_run  = ev[0] & ~ev[1] & ~ev[2];

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic        halt_q, halt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic [15:0] cyc_q, cyc_d;
  logic        bnd;

  assign bnd = t7 & ~halt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      halt_q  <= 1'b1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      halt_q  <= halt_d;
      run_q   <= run_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          ev_step: state_d = S_STEP;
          ev_run:  state_d = S_RUN;
          default: state_d = S_IDLE;
        endcase
      end
      S_RUN: begin
        if (bnd && hlt_req)
          state_d = S_HALTED;
        else if (bnd && (pend_q || ev_stop))
          state_d = S_IDLE;
      end
      S_STEP: begin
        if (bnd)
          state_d = hlt_req ? S_HALTED : S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    halt_d = (state_d == S_IDLE) || (state_d == S_HALTED);
    run_d  = (state_d == S_RUN) || (state_d == S_STEP);
    done_d = (state_q == S_STEP) && bnd && !hlt_req;
    pend_d = (state_q == S_RUN) && (state_d == S_RUN)
           && (pend_q || ev_stop);
    cyc_d  = bnd ? cyc_q + 16'd1 : cyc_q;
  end

  assign halt      = halt_q;
  assign running   = run_q;
  assign step_done = done_q;
  assign cyc_cnt   = cyc_q;

endmodule
